// File: rtl/iob_diff_pkg.sv
// Shared FSM encoding and saturation mode
// constants for the accumulator inverter.
package iob_diff_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } diff_state_t;

  localparam int SAT_WRAP = 0;
  localparam int SAT_ON   = 1;

endpackage

// File: rtl/iob_reg_re.sv
// Register with async reset, clock enable,
// synchronous restart and load enable.
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_data <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        r_data <= RST_VAL;
      end else if (en_i) begin
        r_data <= data_i;
      end
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/iob_diff.sv
// Accumulator inverter: emits the difference
// between consecutive accepted samples.
module iob_diff
  import iob_diff_pkg::*;
#(
  parameter int                DATA_W  = 21,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  parameter int                SAT     = 0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              first_o,
  output logic              ovf_o
);

  localparam int MSB = DATA_W - 1;

  diff_state_t r_state;
  diff_state_t w_state_nxt;

  logic              w_arst;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_valid_en;
  logic [DATA_W-1:0] w_prev;
  logic [DATA_W-1:0] w_wrap;
  logic [DATA_W-1:0] w_sat_val;
  logic [DATA_W-1:0] w_diff;
  logic              w_ovf;
  logic              w_first;

  assign w_arst = ~arst_n_i;

  assign s_ready_o = en_i & cke_i
                   & (~m_valid_o | m_ready_i);

  assign w_in_xfer  = s_valid_i & s_ready_o;
  assign w_out_xfer = m_valid_o & m_ready_i;
  assign w_valid_en = w_in_xfer | w_out_xfer;

  assign w_wrap = s_data_i - w_prev;

  // Signed overflow: operands differ in sign
  // and the result sign disagrees with cur.
  assign w_ovf = (s_data_i[MSB] != w_prev[MSB])
               & (w_wrap[MSB] != s_data_i[MSB]);

  assign w_sat_val = s_data_i[MSB]
                   ? {1'b1, {(DATA_W-1){1'b0}}}
                   : {1'b0, {(DATA_W-1){1'b1}}};

  generate
    if (SAT == SAT_ON) begin : g_sat
      assign w_diff = w_ovf ? w_sat_val : w_wrap;
    end else begin : g_wrap
      assign w_diff = w_wrap;
    end
  endgenerate

  assign w_first = (r_state == PRIME);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cke_i) begin
      unique case (1'b1)
        rst_i:     w_state_nxt = PRIME;
        w_in_xfer: w_state_nxt = RUN;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  iob_reg_re #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_prev (
    .clk_i  (clk_i),
    .arst_i (w_arst),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (w_in_xfer),
    .data_i (s_data_i),
    .data_o (w_prev)
  );

  iob_reg_re #(
    .DATA_W  (DATA_W),
    .RST_VAL ({DATA_W{1'b0}})
  ) u_data (
    .clk_i  (clk_i),
    .arst_i (w_arst),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (w_in_xfer),
    .data_i (w_diff),
    .data_o (m_data_o)
  );

  iob_reg_re #(
    .DATA_W  (1),
    .RST_VAL (1'b0)
  ) u_first (
    .clk_i  (clk_i),
    .arst_i (w_arst),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (w_in_xfer),
    .data_i (w_first),
    .data_o (first_o)
  );

  iob_reg_re #(
    .DATA_W  (1),
    .RST_VAL (1'b0)
  ) u_ovf (
    .clk_i  (clk_i),
    .arst_i (w_arst),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (w_in_xfer),
    .data_i (w_ovf),
    .data_o (ovf_o)
  );

  // Valid stays high when a drain and a
  // new load coincide.
  iob_reg_re #(
    .DATA_W  (1),
    .RST_VAL (1'b0)
  ) u_valid (
    .clk_i  (clk_i),
    .arst_i (w_arst),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (w_valid_en),
    .data_i (w_in_xfer),
    .data_o (m_valid_o)
  );

endmodule
